// File: rtl/matrix_calc_pkg.sv
// Shared constants and state encodings for the matrix storage/display blocks.
package matrix_calc_pkg;

    localparam int MAX_MATRICES = 10;
    localparam int MAX_DIM      = 5;
    localparam int ELEM_W       = 8;
    localparam int DISP_TIMEOUT = 16;

    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    typedef enum logic [2:0] {
        DISP_IDLE,
        DISP_REQ,
        DISP_WAIT_META,
        DISP_FETCH,
        DISP_WAIT_DATA,
        DISP_EMIT,
        DISP_SEP,
        DISP_DONE
    } disp_state_t;

endpackage

// File: rtl/dec3_split.sv
// Splits a signed int8 into sign, three decimal digits and the count of significant digits.
module dec3_split
    import matrix_calc_pkg::*;
(
    input  logic [ELEM_W-1:0] value,
    output logic              neg,
    output logic [3:0]        hundreds,
    output logic [3:0]        tens,
    output logic [3:0]        ones,
    output logic [1:0]        digit_count
);

    // One extra bit so that -128 negates to +128 without overflow.
    logic [ELEM_W:0] mag;

    assign neg         = value[ELEM_W-1];
    assign mag         = neg ? (9'd0 - {value[ELEM_W-1], value}) : {1'b0, value};
    assign hundreds    = 4'(mag / 9'd100);
    assign tens        = 4'((mag / 9'd10) % 9'd10);
    assign ones        = 4'(mag % 9'd10);
    assign digit_count = (mag >= 9'd100) ? 2'd3 : ((mag >= 9'd10) ? 2'd2 : 2'd1);

endmodule

// File: rtl/matrix_display_reader.sv
// Fetches one stored matrix element by element and streams it as ASCII decimal text.
module matrix_display_reader
    import matrix_calc_pkg::*;
#(
    parameter int TIMEOUT = DISP_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [3:0]        disp_id,
    input  logic [2:0]        disp_m,
    input  logic [2:0]        disp_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              start_disp,
    output logic [3:0]        matrix_id_sel,
    output logic              read_en,
    input  logic              meta_info_valid,
    input  logic              matrix_data_valid,
    input  logic [ELEM_W-1:0] data_in,
    input  logic              stor_error,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    disp_state_t       state_reg, state_next;
    logic [3:0]        id_reg, id_next;
    logic [2:0]        m_reg, m_next, n_reg, n_next;
    logic [2:0]        row_reg, row_next, col_reg, col_next;
    logic [ELEM_W-1:0] data_reg, data_next;
    logic [1:0]        char_idx_reg, char_idx_next;
    logic              sep_idx_reg, sep_idx_next;
    logic [7:0]        timer_reg, timer_next;
    logic              err_reg, err_next;

    logic       neg;
    logic [3:0] hundreds, tens, ones;
    logic [1:0] digit_count;
    logic [3:0] digit [3];
    logic [7:0] fmt_byte [4];
    logic [2:0] elem_len;
    logic [1:0] last_char;
    logic       req_bad, last_col, last_row, timed_out;

    dec3_split u_split (
        .value       (data_reg),
        .neg         (neg),
        .hundreds    (hundreds),
        .tens        (tens),
        .ones        (ones),
        .digit_count (digit_count)
    );

    assign digit[0]  = hundreds;
    assign digit[1]  = tens;
    assign digit[2]  = ones;
    assign elem_len  = {2'b00, neg} + {1'b0, digit_count};
    assign last_char = 2'(elem_len - 3'd1);

    // Character slot gi maps onto a digit position once the sign and leading zeros are skipped.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fmt
            logic [2:0] pos;
            assign pos = 3'(gi) + 3'd3 - {1'b0, digit_count} - {2'b00, neg};
            assign fmt_byte[gi] = ((gi == 0) && neg) ? ASCII_MINUS :
                                  (pos < 3'd3) ? (ASCII_ZERO + {4'd0, digit[pos[1:0]]}) :
                                  ASCII_ZERO;
        end
    endgenerate

    assign req_bad   = (int'(disp_id) >= MAX_MATRICES) ||
                       (disp_m == 3'd0) || (int'(disp_m) > MAX_DIM) ||
                       (disp_n == 3'd0) || (int'(disp_n) > MAX_DIM);
    assign last_col  = (col_reg == n_reg - 3'd1);
    assign last_row  = (row_reg == m_reg - 3'd1);
    assign timed_out = (timer_reg == 8'(TIMEOUT - 1));

    assign matrix_id_sel = id_reg;
    assign err           = err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= DISP_IDLE;
            id_reg       <= '0;
            m_reg        <= '0;
            n_reg        <= '0;
            row_reg      <= '0;
            col_reg      <= '0;
            data_reg     <= '0;
            char_idx_reg <= '0;
            sep_idx_reg  <= 1'b0;
            timer_reg    <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            id_reg       <= id_next;
            m_reg        <= m_next;
            n_reg        <= n_next;
            row_reg      <= row_next;
            col_reg      <= col_next;
            data_reg     <= data_next;
            char_idx_reg <= char_idx_next;
            sep_idx_reg  <= sep_idx_next;
            timer_reg    <= timer_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        id_next       = id_reg;
        m_next        = m_reg;
        n_next        = n_reg;
        row_next      = row_reg;
        col_next      = col_reg;
        data_next     = data_reg;
        char_idx_next = char_idx_reg;
        sep_idx_next  = sep_idx_reg;
        timer_next    = timer_reg;
        err_next      = 1'b0;
        busy          = (state_reg != DISP_IDLE) && (state_reg != DISP_DONE);
        done          = (state_reg == DISP_DONE);
        start_disp    = 1'b0;
        read_en       = 1'b0;
        tx_valid      = 1'b0;
        tx_data       = '0;

        case (state_reg)
            DISP_IDLE: begin
                if (disp_req) begin
                    id_next = disp_id;
                    m_next  = disp_m;
                    n_next  = disp_n;
                    if (req_bad) err_next = 1'b1;
                    else         state_next = DISP_REQ;
                end
            end
            DISP_REQ: begin
                start_disp = 1'b1;
                timer_next = '0;
                row_next   = '0;
                col_next   = '0;
                state_next = DISP_WAIT_META;
            end
            DISP_WAIT_META: begin
                timer_next = timer_reg + 8'd1;
                if (stor_error || (!meta_info_valid && timed_out)) begin
                    err_next   = 1'b1;
                    state_next = DISP_IDLE;
                end else if (meta_info_valid) begin
                    state_next = DISP_FETCH;
                end
            end
            DISP_FETCH: begin
                read_en    = 1'b1;
                timer_next = '0;
                state_next = DISP_WAIT_DATA;
            end
            DISP_WAIT_DATA: begin
                timer_next = timer_reg + 8'd1;
                if (stor_error || (!matrix_data_valid && timed_out)) begin
                    err_next   = 1'b1;
                    state_next = DISP_IDLE;
                end else if (matrix_data_valid) begin
                    data_next     = data_in;
                    char_idx_next = '0;
                    state_next    = DISP_EMIT;
                end
            end
            DISP_EMIT: begin
                tx_valid = 1'b1;
                tx_data  = fmt_byte[char_idx_reg];
                if (tx_ready) begin
                    if (char_idx_reg == last_char) begin
                        sep_idx_next = 1'b0;
                        state_next   = DISP_SEP;
                    end else begin
                        char_idx_next = char_idx_reg + 2'd1;
                    end
                end
            end
            DISP_SEP: begin
                tx_valid = 1'b1;
                if (!last_col) tx_data = ASCII_SPACE;
                else           tx_data = sep_idx_reg ? ASCII_LF : ASCII_CR;
                if (tx_ready) begin
                    if (!last_col) begin
                        col_next   = col_reg + 3'd1;
                        state_next = DISP_FETCH;
                    end else if (!sep_idx_reg) begin
                        sep_idx_next = 1'b1;
                    end else if (last_row) begin
                        state_next = DISP_DONE;
                    end else begin
                        row_next   = row_reg + 3'd1;
                        col_next   = '0;
                        state_next = DISP_FETCH;
                    end
                end
            end
            DISP_DONE: state_next = DISP_IDLE;
            default:   state_next = DISP_IDLE;
        endcase
    end

endmodule

// File: tb/tb_matrix_display_reader.sv
// Randomised bench for matrix_display_reader with a storage responder, a TX sink and a text model.
module tb_matrix_display_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       disp_req;
    logic [3:0] disp_id;
    logic [2:0] disp_m, disp_n;
    logic       busy, done, err, start_disp, read_en;
    logic [3:0] matrix_id_sel;
    logic       meta_info_valid, matrix_data_valid, stor_error;
    logic [7:0] data_in;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;

    matrix_display_reader dut (
        .clk               (clk),
        .rst               (rst),
        .disp_req          (disp_req),
        .disp_id           (disp_id),
        .disp_m            (disp_m),
        .disp_n            (disp_n),
        .busy              (busy),
        .done              (done),
        .err               (err),
        .start_disp        (start_disp),
        .matrix_id_sel     (matrix_id_sel),
        .read_en           (read_en),
        .meta_info_valid   (meta_info_valid),
        .matrix_data_valid (matrix_data_valid),
        .data_in           (data_in),
        .stor_error        (stor_error),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic signed [7:0] mem [16][25];
    logic [7:0]        rx_q [$];
    logic [7:0]        exp_q [$];

    int ready_pct = 100;
    int stor_mode = 0;  // 0 responds, 1 reports stor_error, 2 stays silent

    int done_cnt = 0, err_cnt = 0, start_cnt = 0, rd_cnt = 0, txv_cnt = 0, viol_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected text: each element in signed decimal, space between columns, CR LF per row.
    task automatic build_expected(input int id, input int m, input int n);
        string s;
        exp_q.delete();
        for (int r = 0; r < m; r++) begin
            for (int c = 0; c < n; c++) begin
                s = $sformatf("%0d", int'(mem[id][r*n+c]));
                for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
                if (c != n - 1) exp_q.push_back(8'h20);
            end
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    // Storage responder: answers start_disp and read_en after a random 1..3 cycle delay.
    initial begin
        int meta_pend, data_pend, rd_idx;
        logic [3:0] sel;
        meta_pend = 0; data_pend = 0; rd_idx = 0; sel = 0;
        meta_info_valid = 0; matrix_data_valid = 0; stor_error = 0; data_in = 0;
        forever begin
            @(posedge clk); #1;
            meta_info_valid = 0; matrix_data_valid = 0; stor_error = 0;
            if (rst) begin
                meta_pend = 0; data_pend = 0;
            end else begin
                if (meta_pend > 0) begin
                    meta_pend--;
                    if (meta_pend == 0) begin
                        if (stor_mode == 1)      stor_error = 1;
                        else if (stor_mode == 0) meta_info_valid = 1;
                    end
                end
                if (data_pend > 0) begin
                    data_pend--;
                    if (data_pend == 0) begin
                        matrix_data_valid = 1;
                        data_in = (rd_idx < 25) ? mem[sel][rd_idx] : 8'h00;
                        rd_idx++;
                    end
                end
                if (start_disp) begin
                    meta_pend = $urandom_range(1, 3);
                    rd_idx = 0;
                    sel = matrix_id_sel;
                end
                if (read_en) data_pend = $urandom_range(1, 3);
            end
        end
    end

    initial begin
        tx_ready = 0;
        forever begin
            @(posedge clk); #1;
            tx_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Monitor on the falling edge: transfers, pulses and handshake stability.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (tx_valid && tx_ready) rx_q.push_back(tx_data);
            if (tx_valid)   txv_cnt++;
            if (done)       done_cnt++;
            if (err)        err_cnt++;
            if (start_disp) start_cnt++;
            if (read_en)    rd_cnt++;
            if (done && busy) viol_cnt++;
            if (prev_stall && (!tx_valid || tx_data != prev_data)) viol_cnt++;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    task automatic run_disp(input int id, input int m, input int n, input int rdy, input int mode,
                            input bit exp_ok, input int extra_at, output int lat);
        int b_rx, b_done, b_err, b_start, b_rd, b_txv, b_viol, cyc, got;
        string nm;
        b_rx = rx_q.size(); b_done = done_cnt; b_err = err_cnt; b_start = start_cnt;
        b_rd = rd_cnt; b_txv = txv_cnt; b_viol = viol_cnt;
        ready_pct = rdy; stor_mode = mode;
        nm = $sformatf("id%0d_%0dx%0d", id, m, n);
        @(posedge clk); #1;
        disp_req = 1; disp_id = 4'(id); disp_m = 3'(m); disp_n = 3'(n);
        @(posedge clk); #1;
        disp_req = 0;
        check_val({nm, "_start_lat"}, int'(start_disp), 1);
        cyc = 1;
        while (done_cnt == b_done && err_cnt == b_err && cyc < 6000) begin
            if (cyc == extra_at) begin
                disp_req = 1; disp_id = 4'd12; disp_m = 3'd2; disp_n = 3'd2;
            end else begin
                disp_req = 0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        disp_req = 0;
        if (cyc >= 6000) check_val({nm, "_finished"}, 0, 1);
        lat = cyc - 1;
        repeat (3) @(posedge clk);
        #1;
        check_val({nm, "_busy_end"}, int'(busy), 0);
        check_val({nm, "_start_cnt"}, start_cnt - b_start, 1);
        check_val({nm, "_viol"}, viol_cnt - b_viol, 0);
        if (exp_ok) begin
            build_expected(id, m, n);
            check_val({nm, "_done_cnt"}, done_cnt - b_done, 1);
            check_val({nm, "_err_cnt"}, err_cnt - b_err, 0);
            check_val({nm, "_read_en"}, rd_cnt - b_rd, m * n);
            check_val({nm, "_nbytes"}, rx_q.size() - b_rx, exp_q.size());
            for (int i = 0; i < exp_q.size(); i++) begin
                got = (b_rx + i < rx_q.size()) ? int'(rx_q[b_rx + i]) : -1;
                check_val($sformatf("%s_byte%0d", nm, i), got, int'(exp_q[i]));
                if (got != int'(exp_q[i])) break;
            end
        end else begin
            check_val({nm, "_err_cnt"}, err_cnt - b_err, 1);
            check_val({nm, "_done_cnt"}, done_cnt - b_done, 0);
            check_val({nm, "_tx_valid"}, txv_cnt - b_txv, 0);
        end
    endtask

    task automatic bad_req(input int id, input int m, input int n);
        int b_start;
        string nm;
        nm = $sformatf("bad_id%0d_%0dx%0d", id, m, n);
        b_start = start_cnt;
        @(posedge clk); #1;
        disp_req = 1; disp_id = 4'(id); disp_m = 3'(m); disp_n = 3'(n);
        @(posedge clk); #1;
        disp_req = 0;
        check_val({nm, "_err"}, int'(err), 1);
        check_val({nm, "_busy"}, int'(busy), 0);
        @(posedge clk); #1;
        check_val({nm, "_err_width"}, int'(err), 0);
        repeat (4) @(posedge clk);
        #1;
        check_val({nm, "_no_start"}, start_cnt - b_start, 0);
    endtask

    initial begin
        int lat, b_rx, b_done, b_err, cyc, m, n, id;
        rst = 1; disp_req = 0; disp_id = 0; disp_m = 0; disp_n = 0;
        for (int i = 0; i < 16; i++)
            for (int k = 0; k < 25; k++) mem[i][k] = 8'($urandom);
        mem[3][0] = 1; mem[3][1] = -2; mem[3][2] = 30; mem[3][3] = 127;
        mem[5][0] = -128; mem[5][1] = 0; mem[5][2] = 100;
        for (int k = 0; k < 25; k++) mem[9][k] = 127;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_err", int'(err), 0);
        check_val("rst_start", int'(start_disp), 0);
        check_val("rst_read_en", int'(read_en), 0);
        check_val("rst_tx_valid", int'(tx_valid), 0);
        check_val("rst_tx_data", int'(tx_data), 0);
        check_val("rst_id_sel", int'(matrix_id_sel), 0);
        rst = 0;

        run_disp(3, 2, 2, 100, 0, 1, 0, lat);
        run_disp(5, 1, 3, 100, 0, 1, 0, lat);
        run_disp(3, 2, 2, 50, 0, 1, 0, lat);
        run_disp(9, 5, 5, 100, 0, 1, 0, lat);
        run_disp(3, 2, 2, 100, 0, 1, 6, lat);

        bad_req(12, 2, 2);
        bad_req(2, 0, 3);
        bad_req(2, 3, 6);

        run_disp(4, 2, 2, 100, 1, 0, 0, lat);
        run_disp(4, 2, 2, 100, 2, 0, 0, lat);
        check_val("timeout_latency_in_range", int'(lat >= 17 && lat <= 19), 1);

        // Reset in the middle of the text stream, then a clean request.
        ready_pct = 30; stor_mode = 0;
        b_rx = rx_q.size();
        @(posedge clk); #1;
        disp_req = 1; disp_id = 9; disp_m = 5; disp_n = 5;
        @(posedge clk); #1;
        disp_req = 0;
        cyc = 0;
        while (!(rx_q.size() - b_rx >= 3 && tx_valid) && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 4000) check_val("mid_stream_reached", 0, 1);
        b_done = done_cnt; b_err = err_cnt;
        rst = 1;
        @(posedge clk); #1;
        check_val("midrst_tx_valid", int'(tx_valid), 0);
        check_val("midrst_busy", int'(busy), 0);
        rst = 0;
        repeat (6) @(posedge clk);
        #1;
        check_val("midrst_no_done", done_cnt - b_done, 0);
        check_val("midrst_no_err", err_cnt - b_err, 0);
        run_disp(3, 2, 2, 100, 0, 1, 0, lat);

        for (int t = 0; t < 6; t++) begin
            id = t % 3;
            m = $urandom_range(1, 5);
            n = $urandom_range(1, 5);
            for (int k = 0; k < 25; k++) mem[id][k] = 8'($urandom);
            run_disp(id, m, n, $urandom_range(30, 100), 0, 1, 0, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
